mem_wb_skid_stage: RTL and testbench
====================================

# mem_wb_skid_stage

Parametrised memory/writeback pipeline stage with a valid/ready handshake and a two-entry skid buffer. It carries the ALU result, the data-memory read value and the instruction word from the memory stage to the writeback stage. Unlike a plain always-enabled latch, it supports backpressure from writeback, a registered `in_ready` with no combinational ready path, and a pipeline flush. It sits between the memory-access stage and the register-file write logic.

## Interface

Parameters:
- `DATA_W`, default 32: width of `alu` and `dmem` fields.
- `INSN_W`, default 32: width of the instruction field.
- `NOP_INSN`, default `32'h0000_0000`: instruction value presented on bubbles (used only with `MEM_WB_NOP_BUBBLE_EN`).

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous discard of all held entries.
- `in_valid` in 1: upstream entry valid.
- `in_ready` out 1: stage can accept an entry; driven directly from a register.
- `in_alu` in `DATA_W`: ALU result.
- `in_dmem` in `DATA_W`: data-memory read value.
- `in_insn` in `INSN_W`: instruction word.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: writeback accepts the head entry.
- `out_alu`, `out_dmem` out `DATA_W`; `out_insn` out `INSN_W`: head entry fields.
- `occupancy` out 2: entries held, 0..2.

## Operation

- Storage: main register M (drives outputs) and skid register S. Each holds {alu, dmem, insn}.
- Accept = `in_valid & in_ready`. Retire = `out_valid & out_ready`.
- States:
  - EMPTY (occ 0): `in_ready`=1, `out_valid`=0. Accept → M←in, go to ONE.
  - ONE (occ 1): `in_ready`=1, `out_valid`=1.
    - Accept & retire → M←in, stay ONE.
    - Accept only → S←in, go to FULL.
    - Retire only → EMPTY.
  - FULL (occ 2): `in_ready`=0, `out_valid`=1. Retire → M←S, go to ONE. Otherwise hold.
- Order is strict FIFO. No entry is dropped or duplicated except by flush or reset.
- `in_*` is ignored when there is no accept. `out_*` stays stable while `out_valid & !out_ready`.
- Flush: on the next edge the state goes to EMPTY, `occupancy`=0 and `in_ready`=1. Any same-cycle accept or retire is ignored. Data registers keep their contents.
- Priority: `reset` > `flush` > handshake.
- Reset: state EMPTY; M and S cleared to 0. After reset: `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_alu`=`out_dmem`=0, `out_insn`=0 (or `NOP_INSN` with the macro). Reset mid-transfer discards all held entries.
- No arithmetic is performed. Fields pass through bit-exact at their parameter widths.

## Timing

- Latency: an entry accepted at edge N appears on `out_*` with `out_valid`=1 after edge N when the stage is EMPTY or retiring in the same cycle. Otherwise it waits behind the entries ahead of it.
- Throughput: 1 entry/cycle when `out_ready` is held high.
- `in_ready` is registered. It falls the cycle after the transition to FULL, and rises the cycle after the retire out of FULL.
- No combinational path exists from any input to `in_ready`, `out_valid` or `occupancy`. `out_*` data is also registered (or muxed with `out_valid` under the macro).

## Configuration

- `MEM_WB_NOP_BUBBLE_EN` defined: when `out_valid`=0, `out_insn` is forced to `NOP_INSN` and `out_alu`/`out_dmem` are forced to 0. This makes bubbles harmless to writeback logic that does not check `out_valid`.
- Not defined: when `out_valid`=0, the `out_*` ports show the stale contents of M.
- Handshake behaviour is identical in both builds.

## Test plan

- Reset, then idle → `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_insn`=0 (or `NOP_INSN`).
- Stream 8 entries (alu=i, dmem=0x100+i, insn=0x200+i) with `out_ready`=1 → 8 consecutive outputs in order, one per cycle, one cycle after each accept; `occupancy` stays at 1.
- Push 3 entries back-to-back with `out_ready`=0 → 2 accepted, `occupancy`=2, `in_ready`=0 from the cycle after the second accept. Raise `out_ready` → entries 0,1,2 retire in order with no loss.
- With `occupancy`=2, assert `flush` together with `in_valid` and `out_ready` → next cycle `out_valid`=0, `occupancy`=0, `in_ready`=1. The in-flight entry is not captured.
- Assert `reset` while FULL with `in_valid`=1 → all outputs return to their reset values and no entry emerges afterward.
- Hold `out_ready`=0 while `in_*` toggles randomly → `out_*` stays stable while `out_valid`=1. Build with and without `MEM_WB_NOP_BUBBLE_EN` and check bubble outputs (NOP/0 vs. stale M).

Source files
------------

// File: rtl/mem_wb_skid_stage.sv
// Memory-to-writeback pipeline register with a two-entry skid buffer, flush and registered in_ready.
// Optional build macro MEM_WB_NOP_BUBBLE_EN: forces NOP/zero onto out_* whenever out_valid is low.
module mem_wb_skid_stage #(
   parameter int                DATA_W   = 32,
   parameter int                INSN_W   = 32,
   parameter logic [INSN_W-1:0] NOP_INSN = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [DATA_W-1:0] in_dmem,
   input  logic [INSN_W-1:0] in_insn,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_alu,
   output logic [DATA_W-1:0] out_dmem,
   output logic [INSN_W-1:0] out_insn,
   output logic [1:0]        occupancy,
   output logic [1:0]        state_dbg
);

`ifdef MEM_WB_NOP_BUBBLE_EN
   localparam bit bubble_en = 1'b1;
`else
   localparam bit bubble_en = 1'b0;
`endif

   typedef struct packed {
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] dmem;
      logic [INSN_W-1:0] insn;
   } entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t     state_q, state_d;
   entry_t     m_q, m_d;
   entry_t     s_q, s_d;
   logic       in_ready_q, in_ready_d;
   logic       out_valid_q, out_valid_d;
   logic [1:0] occ_q, occ_d;
   entry_t     in_entry;
   logic       accept;
   logic       retire;

   // Handshake: an entry moves on a rising edge where valid and ready are both high; valid never
   // waits on ready, and in_ready/out_valid/occupancy come straight from flops.
   assign in_entry = {in_alu, in_dmem, in_insn};
   assign accept   = in_valid & in_ready_q;
   assign retire   = out_valid_q & out_ready;

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      s_d     = s_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  m_d     = in_entry;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && retire) begin
                  m_d = in_entry;
               end else if (accept) begin
                  s_d     = in_entry;
                  state_d = ST_FULL;
               end else if (retire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (retire) begin
                  m_d     = s_q;
                  state_d = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      // Status flops are a pure function of the next state, so they never see an input combinationally.
      in_ready_d  = (state_d != ST_FULL);
      out_valid_d = (state_d != ST_EMPTY);
      occ_d       = state_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         m_q         <= '0;
         s_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         occ_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         m_q         <= m_d;
         s_q         <= s_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         occ_q       <= occ_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign occupancy = occ_q;
   assign state_dbg = state_q;
   assign out_alu   = (bubble_en && !out_valid_q) ? '0 : m_q.alu;
   assign out_dmem  = (bubble_en && !out_valid_q) ? '0 : m_q.dmem;
   assign out_insn  = (bubble_en && !out_valid_q) ? NOP_INSN : m_q.insn;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Bench for mem_wb_skid_stage: queue model of a 2-deep FIFO checked every cycle, plus directed literals.
module tb_mem_wb_skid_stage;
   localparam int DATA_W = 32;
   localparam int INSN_W = 32;
   localparam int W      = 2 * DATA_W + INSN_W;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_alu = '0;
   logic [DATA_W-1:0] in_dmem = '0;
   logic [INSN_W-1:0] in_insn = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_alu;
   logic [DATA_W-1:0] out_dmem;
   logic [INSN_W-1:0] out_insn;
   logic [1:0]        occupancy;
   logic [1:0]        state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] last_head = '0;

   mem_wb_skid_stage #(.DATA_W(DATA_W), .INSN_W(INSN_W), .NOP_INSN(32'h0000_0000)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu(in_alu), .in_dmem(in_dmem), .in_insn(in_insn),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_alu(out_alu), .out_dmem(out_dmem), .out_insn(out_insn),
      .occupancy(occupancy), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // driver: apply one cycle of inputs, step past the edge, leave #1 settle time
   task automatic drive(input logic v, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [INSN_W-1:0] i, input logic ordy, input logic fl, input logic rst);
      in_valid  = v;
      in_alu    = a;
      in_dmem   = d;
      in_insn   = i;
      out_ready = ordy;
      flush     = fl;
      reset     = rst;
      @(posedge clock);
      #1;
   endtask

   function automatic logic [W-1:0] pack(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d,
                                         input logic [INSN_W-1:0] i);
      return {a, d, i};
   endfunction

   function automatic logic [W-1:0] bubble_exp();
`ifdef MEM_WB_NOP_BUBBLE_EN
      return {{DATA_W{1'b0}}, {DATA_W{1'b0}}, 32'h0000_0000};
`else
      return last_head;
`endif
   endfunction

   // scoreboard model: an ordered queue of at most two entries
   initial begin
      forever begin
         @(posedge clock);
         if (reset) begin
            exp_q.delete();
            last_head = '0;
            chk_en    = 1'b1;
         end else if (flush) begin
            exp_q.delete();
         end else begin
            bit acc;
            bit ret;
            acc = in_valid && (exp_q.size() < 2);
            ret = out_ready && (exp_q.size() > 0);
            if (ret) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(pack(in_alu, in_dmem, in_insn));
            if (exp_q.size() > 0) last_head = exp_q[0];
         end
      end
   end

   // compare process, away from the active edge
   initial begin
      forever begin
         @(negedge clock);
         if (chk_en) begin
            chk("in_ready", W'(in_ready), W'(exp_q.size() < 2));
            chk("out_valid", W'(out_valid), W'(exp_q.size() > 0));
            chk("occupancy", W'(occupancy), W'(exp_q.size()));
            if (exp_q.size() > 0) chk("head", {out_alu, out_dmem, out_insn}, exp_q[0]);
            else                  chk("bubble", {out_alu, out_dmem, out_insn}, bubble_exp());
         end
      end
   end

   initial begin
      logic [W-1:0] held;
      // reset and idle
      drive(0, 0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_in_ready", W'(in_ready), W'(1));
      chk("rst_occupancy", W'(occupancy), W'(0));
      chk("rst_fields", {out_alu, out_dmem, out_insn}, '0);

      // streaming with out_ready high: each entry visible right after its accept
      for (int i = 0; i < 8; i++) begin
         drive(1, DATA_W'(i), DATA_W'(32'h100 + i), INSN_W'(32'h200 + i), 1, 0, 0);
         chk("stream_data", {out_alu, out_dmem, out_insn},
             pack(DATA_W'(i), DATA_W'(32'h100 + i), INSN_W'(32'h200 + i)));
         chk("stream_occ", W'(occupancy), W'(1));
         chk("stream_valid", W'(out_valid), W'(1));
      end
      drive(0, 0, 0, 0, 1, 0, 0);
      chk("stream_drained", W'(out_valid), W'(0));

      // backpressure: third push is held by upstream until taken
      drive(1, 32'h10, 32'h110, 32'h210, 0, 0, 0);
      chk("bp_occ1", W'(occupancy), W'(1));
      drive(1, 32'h11, 32'h111, 32'h211, 0, 0, 0);
      chk("bp_occ2", W'(occupancy), W'(2));
      chk("bp_ready_low", W'(in_ready), W'(0));
      drive(1, 32'h12, 32'h112, 32'h212, 0, 0, 0);
      chk("bp_hold_head", W'(out_alu), W'(32'h10));
      chk("bp_still_full", W'(occupancy), W'(2));
      drive(1, 32'h12, 32'h112, 32'h212, 1, 0, 0);
      chk("bp_retire0", W'(out_alu), W'(32'h11));
      chk("bp_ready_back", W'(in_ready), W'(1));
      drive(1, 32'h12, 32'h112, 32'h212, 1, 0, 0);
      chk("bp_retire1", {out_alu, out_dmem, out_insn}, pack(32'h12, 32'h112, 32'h212));
      drive(0, 0, 0, 0, 1, 0, 0);
      chk("bp_retire2", W'(out_valid), W'(0));

      // flush while full, with a competing accept and retire
      drive(1, 32'h20, 32'h120, 32'h220, 0, 0, 0);
      drive(1, 32'h21, 32'h121, 32'h221, 0, 0, 0);
      drive(1, 32'h22, 32'h122, 32'h222, 1, 1, 0);
      chk("flush_valid", W'(out_valid), W'(0));
      chk("flush_occ", W'(occupancy), W'(0));
      chk("flush_ready", W'(in_ready), W'(1));
      drive(0, 0, 0, 0, 1, 0, 0);
      chk("flush_no_capture", W'(out_valid), W'(0));

      // reset while full with in_valid high
      drive(1, 32'h30, 32'h130, 32'h230, 0, 0, 0);
      drive(1, 32'h31, 32'h131, 32'h231, 0, 0, 0);
      drive(1, 32'h32, 32'h132, 32'h232, 0, 0, 1);
      chk("midrst_occ", W'(occupancy), W'(0));
      chk("midrst_fields", {out_alu, out_dmem, out_insn}, '0);
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 0, 1, 0, 0);
         chk("midrst_nothing", W'(out_valid), W'(0));
      end

      // head must stay stable under backpressure while inputs churn
      drive(1, 32'h40, 32'h140, 32'h240, 0, 0, 0);
      held = pack(32'h40, 32'h140, 32'h240);
      for (int k = 0; k < 20; k++) begin
         drive(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 0, 0, 0);
         chk("hold_stable", {out_alu, out_dmem, out_insn}, held);
      end
      for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 1, 0, 0);

      // bubble contents after a known last head
      drive(1, 32'h55, 32'h155, 32'h255, 1, 0, 0);
      drive(0, 0, 0, 0, 1, 0, 0);
`ifdef MEM_WB_NOP_BUBBLE_EN
      chk("bubble_lit", {out_alu, out_dmem, out_insn}, '0);
`else
      chk("bubble_lit", {out_alu, out_dmem, out_insn}, pack(32'h55, 32'h155, 32'h255));
`endif
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clock);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
